// File: rtl/fe_fifo_decoder.sv
`default_nettype none
// ============================================================================
// Module      : fe_fifo_decoder
// Description : Pops capture-FIFO entries, rebuilds absolute event timestamps
//               and presents one decoded USB event at a time on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fe_fifo_decoder #(
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pABS_TIME_WIDTH       = 32,
    parameter int pCOUNT_WIDTH          = 16
) (
    input  logic                             fe_clk,
    input  logic                             reset_i,
    input  logic                             I_enable,
    input  logic                             I_clear,
    input  logic                             I_fifo_empty,
    output logic                             O_fifo_rd,
    input  logic [1:0]                       I_command,
    input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_time,
    input  logic [7:0]                       I_data,
    input  logic [4:0]                       I_status,
    output logic                             O_valid,
    input  logic                             I_ready,
    output logic                             O_is_data,
    output logic [7:0]                       O_data,
    output logic [4:0]                       O_status,
    output logic [pABS_TIME_WIDTH-1:0]       O_abs_time,
    output logic                             O_sop,
    output logic                             O_format_error,
    output logic [pCOUNT_WIDTH-1:0]          O_event_count
);

    localparam logic [1:0] c_CMD_DATA     = 2'b00;
    localparam logic [1:0] c_CMD_STAT     = 2'b01;
    localparam logic [1:0] c_CMD_TIME     = 2'b10;
    localparam int         c_RXACTIVE_BIT = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                       r_state_q,       w_state_d;
    logic [pABS_TIME_WIDTH-1:0]   r_acc_q,         w_acc_d;
    logic                         r_first_q,       w_first_d;
    logic                         r_pkt_open_q,    w_pkt_open_d;
    logic                         r_valid_q,       w_valid_d;
    logic                         r_is_data_q,     w_is_data_d;
    logic [7:0]                   r_data_q,        w_data_d;
    logic [4:0]                   r_status_q,      w_status_d;
    logic [pABS_TIME_WIDTH-1:0]   r_abs_time_q,    w_abs_time_d;
    logic                         r_sop_q,         w_sop_d;
    logic                         r_format_err_q,  w_format_err_d;
    logic [pCOUNT_WIDTH-1:0]      r_event_count_q, w_event_count_d;
    logic                         w_fifo_rd;

    logic [pABS_TIME_WIDTH-1:0]   w_time_ext;
    logic [pABS_TIME_WIDTH-1:0]   w_event_acc;

    assign w_time_ext  = pABS_TIME_WIDTH'(I_time);
    // Deltas count idle cycles between events, so every event after the first
    // adds one cycle for itself.
    assign w_event_acc = r_acc_q + w_time_ext
                       + {{(pABS_TIME_WIDTH-1){1'b0}}, ~r_first_q};

    always_comb begin
        w_state_d       = r_state_q;
        w_acc_d         = r_acc_q;
        w_first_d       = r_first_q;
        w_pkt_open_d    = r_pkt_open_q;
        w_valid_d       = r_valid_q;
        w_is_data_d     = r_is_data_q;
        w_data_d        = r_data_q;
        w_status_d      = r_status_q;
        w_abs_time_d    = r_abs_time_q;
        w_sop_d         = r_sop_q;
        w_format_err_d  = r_format_err_q;
        w_event_count_d = r_event_count_q;
        w_fifo_rd       = 1'b0;

        if (I_clear) begin
            w_state_d       = S_IDLE;
            w_valid_d       = 1'b0;
            w_acc_d         = '0;
            w_first_d       = 1'b1;
            w_pkt_open_d    = 1'b0;
            w_format_err_d  = 1'b0;
            w_event_count_d = '0;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (I_enable && !I_fifo_empty && !reset_i) begin
                        w_fifo_rd = 1'b1;
                        w_state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_state_d = S_IDLE;
                    case (I_command)
                        c_CMD_TIME: begin
                            w_acc_d = r_acc_q + w_time_ext;
                        end
                        c_CMD_DATA, c_CMD_STAT: begin
                            w_acc_d      = w_event_acc;
                            w_first_d    = 1'b0;
                            w_abs_time_d = w_event_acc;
                            w_data_d     = I_data;
                            w_status_d   = I_status;
                            w_is_data_d  = (I_command == c_CMD_DATA);
                            w_valid_d    = 1'b1;
                            w_state_d    = S_OUT;
                            if (I_command == c_CMD_DATA) begin
                                w_sop_d      = !r_pkt_open_q;
                                w_pkt_open_d = 1'b1;
                            end else begin
                                w_sop_d = 1'b0;
                                if (!I_status[c_RXACTIVE_BIT]) begin
                                    w_pkt_open_d = 1'b0;
                                end
                            end
                        end
                        default: begin
                            w_format_err_d = 1'b1;
                        end
                    endcase
                end
                S_OUT: begin
                    if (I_ready) begin
                        w_valid_d = 1'b0;
                        w_state_d = S_IDLE;
                        if (r_event_count_q != {pCOUNT_WIDTH{1'b1}}) begin
                            w_event_count_d = r_event_count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            r_state_q       <= S_IDLE;
            r_acc_q         <= '0;
            r_first_q       <= 1'b1;
            r_pkt_open_q    <= 1'b0;
            r_valid_q       <= 1'b0;
            r_is_data_q     <= 1'b0;
            r_data_q        <= '0;
            r_status_q      <= '0;
            r_abs_time_q    <= '0;
            r_sop_q         <= 1'b0;
            r_format_err_q  <= 1'b0;
            r_event_count_q <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_acc_q         <= w_acc_d;
            r_first_q       <= w_first_d;
            r_pkt_open_q    <= w_pkt_open_d;
            r_valid_q       <= w_valid_d;
            r_is_data_q     <= w_is_data_d;
            r_data_q        <= w_data_d;
            r_status_q      <= w_status_d;
            r_abs_time_q    <= w_abs_time_d;
            r_sop_q         <= w_sop_d;
            r_format_err_q  <= w_format_err_d;
            r_event_count_q <= w_event_count_d;
        end
    end

    assign O_fifo_rd      = w_fifo_rd;
    assign O_valid        = r_valid_q;
    assign O_is_data      = r_is_data_q;
    assign O_data         = r_data_q;
    assign O_status       = r_status_q;
    assign O_abs_time     = r_abs_time_q;
    assign O_sop          = r_sop_q;
    assign O_format_error = r_format_err_q;
    assign O_event_count  = r_event_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fe_fifo_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fe_fifo_decoder
// Description : Directed self-checking bench for fe_fifo_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fe_fifo_decoder;

    localparam logic [1:0] c_DATA = 2'b00;
    localparam logic [1:0] c_STAT = 2'b01;
    localparam logic [1:0] c_TIME = 2'b10;
    localparam logic [1:0] c_BAD  = 2'b11;

    logic        fe_clk = 1'b0;
    logic        reset_i;
    logic        i_enable, i_clear, i_ready;
    logic        w_rd, w_wide_rd;
    logic        w_valid, w_is_data, w_sop, w_err;
    logic [7:0]  w_data;
    logic [4:0]  w_status;
    logic [31:0] w_abs;
    logic [15:0] w_count;
    logic        w_wide_valid, w_wide_is_data, w_wide_sop, w_wide_err;
    logic [7:0]  w_wide_data;
    logic [4:0]  w_wide_status;
    logic [31:0] w_wide_abs;
    logic [3:0]  w_wide_count;

    // FIFO model: entries written from tasks between edges, popped on O_fifo_rd
    logic [46:0] mem [0:127];
    int          push_cnt = 0;
    int          pop_cnt  = 0;
    int          rd_empty_err = 0;
    logic [46:0] r_word = '0;
    logic        w_empty;

    assign w_empty = (push_cnt == pop_cnt);

    always #5 fe_clk = ~fe_clk;

    always @(posedge fe_clk) begin
        if (w_rd) begin
            if (push_cnt == pop_cnt) rd_empty_err <= rd_empty_err + 1;
            r_word  <= mem[pop_cnt % 128];
            pop_cnt <= pop_cnt + 1;
        end
    end

    fe_fifo_decoder u_dut (
        .fe_clk(fe_clk), .reset_i(reset_i), .I_enable(i_enable), .I_clear(i_clear),
        .I_fifo_empty(w_empty), .O_fifo_rd(w_rd), .I_command(r_word[46:45]),
        .I_time(r_word[28:13]), .I_data(r_word[12:5]), .I_status(r_word[4:0]),
        .O_valid(w_valid), .I_ready(i_ready), .O_is_data(w_is_data), .O_data(w_data),
        .O_status(w_status), .O_abs_time(w_abs), .O_sop(w_sop),
        .O_format_error(w_err), .O_event_count(w_count)
    );

    // Wide-delta, narrow-counter instance makes wrap and saturation reachable quickly
    fe_fifo_decoder #(.pTIMESTAMP_FULL_WIDTH(32), .pABS_TIME_WIDTH(32), .pCOUNT_WIDTH(4)) u_wide (
        .fe_clk(fe_clk), .reset_i(reset_i), .I_enable(i_enable), .I_clear(i_clear),
        .I_fifo_empty(w_empty), .O_fifo_rd(w_wide_rd), .I_command(r_word[46:45]),
        .I_time(r_word[44:13]), .I_data(r_word[12:5]), .I_status(r_word[4:0]),
        .O_valid(w_wide_valid), .I_ready(i_ready), .O_is_data(w_wide_is_data),
        .O_data(w_wide_data), .O_status(w_wide_status), .O_abs_time(w_wide_abs),
        .O_sop(w_wide_sop), .O_format_error(w_wide_err), .O_event_count(w_wide_count)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    logic        ev_ok, ev_isd, ev_sop;
    logic [7:0]  ev_d;
    logic [31:0] ev_abs, ev_wabs;

    task automatic push(input logic [1:0] c, input logic [31:0] t, input logic [7:0] d,
                        input logic [4:0] s);
        mem[push_cnt % 128] = {c, t, d, s};
        push_cnt = push_cnt + 1;
    endtask

    task automatic pulse_clear();
        @(negedge fe_clk);
        i_clear = 1'b1;
        @(negedge fe_clk);
        i_clear = 1'b0;
    endtask

    // Waits (bounded) for an event, captures it, then lets the handshake complete.
    task automatic get_event();
        ev_ok = 1'b0;
        for (int i = 0; i < 60 && !ev_ok; i++) begin
            @(negedge fe_clk);
            if (w_valid === 1'b1) begin
                ev_ok = 1'b1; ev_isd = w_is_data; ev_sop = w_sop;
                ev_d = w_data; ev_abs = w_abs; ev_wabs = w_wide_abs;
            end
        end
        @(negedge fe_clk);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; i_enable = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
        repeat (3) @(negedge fe_clk);
        n_asserts++;
        if ({w_rd, w_valid, w_is_data, w_data, w_status, w_abs, w_sop, w_err, w_count} !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%b rd=%b abs=%h cnt=%h err=%b, expected all zero",
                     w_valid, w_rd, w_abs, w_count, w_err);
        end
        reset_i = 1'b0;
        @(negedge fe_clk);
        i_enable = 1'b1;
    endtask

    task automatic test_basic();
        push(c_DATA, 32'd5, 8'hA5, 5'b00001);
        push(c_DATA, 32'd0, 8'h3C, 5'b00001);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd5 || ev_sop !== 1'b1 || ev_isd !== 1'b1 || ev_d !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_ev1: ok=%b abs=%h sop=%b isd=%b d=%h, expected abs=5 sop=1 isd=1 d=a5",
                     ev_ok, ev_abs, ev_sop, ev_isd, ev_d);
        end
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd6 || ev_sop !== 1'b0 || ev_d !== 8'h3C) begin
            n_fail++;
            $display("FAIL basic_ev2: ok=%b abs=%h sop=%b d=%h, expected abs=6 sop=0 d=3c",
                     ev_ok, ev_abs, ev_sop, ev_d);
        end
        repeat (5) @(negedge fe_clk);
        n_asserts++;
        if (w_count !== 16'd2 || pop_cnt !== 2) begin
            n_fail++;
            $display("FAIL basic_count: count=%0d pops=%0d, expected count=2 pops=2", w_count, pop_cnt);
        end
    endtask

    task automatic test_time_entries();
        pulse_clear();
        push(c_DATA, 32'd10,     8'h01, 5'b00001);
        push(c_TIME, 32'hFFFE,   8'h00, 5'b00000);
        push(c_TIME, 32'hFFFE,   8'h00, 5'b00000);
        push(c_DATA, 32'd0,      8'h02, 5'b00001);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd10 || ev_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL time_ev1: ok=%b abs=%h sop=%b, expected abs=a sop=1", ev_ok, ev_abs, ev_sop);
        end
        get_event();
        // 0xA + 0xFFFE + 0xFFFE + 0 + 1
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'h0002_0007 || ev_sop !== 1'b0 || ev_d !== 8'h02) begin
            n_fail++;
            $display("FAIL time_ev2: ok=%b abs=%h sop=%b d=%h, expected abs=00020007 sop=0 d=02",
                     ev_ok, ev_abs, ev_sop, ev_d);
        end
        n_asserts++;
        if (w_count !== 16'd2 || pop_cnt !== 6) begin
            n_fail++;
            $display("FAIL time_count: count=%0d pops=%0d, expected count=2 pops=6", w_count, pop_cnt);
        end
    endtask

    task automatic test_backpressure();
        int pops_held;
        bit seen;
        pulse_clear();
        i_ready = 1'b0;
        push(c_DATA, 32'd1, 8'h11, 5'b00001);
        push(c_DATA, 32'd2, 8'h22, 5'b00001);
        push(c_DATA, 32'd3, 8'h33, 5'b00001);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge fe_clk);
            seen = (w_valid === 1'b1);
        end
        pops_held = pop_cnt;
        for (int i = 0; i < 20; i++) begin
            n_asserts++;
            if (!seen || w_valid !== 1'b1 || w_abs !== 32'd1 || w_data !== 8'h11 ||
                w_sop !== 1'b1 || pop_cnt !== pops_held) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b abs=%h d=%h sop=%b pops=%0d, expected valid=1 abs=1 d=11 sop=1 pops=%0d",
                         i, w_valid, w_abs, w_data, w_sop, pop_cnt, pops_held);
            end
            @(negedge fe_clk);
        end
        i_ready = 1'b1;
        @(negedge fe_clk);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd4 || ev_d !== 8'h22 || ev_sop !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ev2: ok=%b abs=%h d=%h sop=%b, expected abs=4 d=22 sop=0", ev_ok, ev_abs, ev_d, ev_sop);
        end
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd8 || ev_d !== 8'h33 || w_count !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_ev3: ok=%b abs=%h d=%h count=%0d, expected abs=8 d=33 count=3",
                     ev_ok, ev_abs, ev_d, w_count);
        end
    endtask

    task automatic test_packet_framing();
        pulse_clear();
        push(c_DATA, 32'd0, 8'hA1, 5'b00001);
        push(c_STAT, 32'd2, 8'h00, 5'b00000);
        push(c_DATA, 32'd1, 8'hA2, 5'b00001);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd0 || ev_sop !== 1'b1 || ev_isd !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_ev1: ok=%b abs=%h sop=%b isd=%b, expected abs=0 sop=1 isd=1", ev_ok, ev_abs, ev_sop, ev_isd);
        end
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd3 || ev_sop !== 1'b0 || ev_isd !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_stat: ok=%b abs=%h sop=%b isd=%b, expected abs=3 sop=0 isd=0", ev_ok, ev_abs, ev_sop, ev_isd);
        end
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd5 || ev_sop !== 1'b1 || ev_isd !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_ev3: ok=%b abs=%h sop=%b isd=%b, expected abs=5 sop=1 isd=1", ev_ok, ev_abs, ev_sop, ev_isd);
        end
    endtask

    task automatic test_format_error();
        pulse_clear();
        n_asserts++;
        if (w_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_initial: err=%b, expected 0", w_err);
        end
        push(c_DATA, 32'd4,   8'h01, 5'b00001);
        push(c_BAD,  32'd100, 8'hEE, 5'b00001);
        push(c_DATA, 32'd2,   8'h02, 5'b00001);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd4) begin
            n_fail++;
            $display("FAIL err_ev1: ok=%b abs=%h, expected abs=4", ev_ok, ev_abs);
        end
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd7 || ev_d !== 8'h02 || w_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_ev2: ok=%b abs=%h d=%h err=%b, expected abs=7 d=02 err=1", ev_ok, ev_abs, ev_d, w_err);
        end
        repeat (5) @(negedge fe_clk);
        n_asserts++;
        if (w_err !== 1'b1 || w_count !== 16'd2) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b count=%0d, expected err=1 count=2", w_err, w_count);
        end
        pulse_clear();
        n_asserts++;
        if (w_err !== 1'b0 || w_count !== 16'd0 || w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b count=%0d valid=%b, expected 0 0 0", w_err, w_count, w_valid);
        end
        push(c_DATA, 32'd9, 8'h09, 5'b00001);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd9 || ev_sop !== 1'b1) begin
            n_fail++;
            $display("FAIL err_after_clear: ok=%b abs=%h sop=%b, expected abs=9 sop=1", ev_ok, ev_abs, ev_sop);
        end
    endtask

    task automatic test_clear_priority();
        bit seen;
        pulse_clear();
        i_ready = 1'b0;
        push(c_DATA, 32'd5, 8'h55, 5'b00001);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge fe_clk);
            seen = (w_valid === 1'b1);
        end
        i_ready = 1'b1;
        i_clear = 1'b1;
        @(negedge fe_clk);
        i_clear = 1'b0;
        n_asserts++;
        if (!seen || w_valid !== 1'b0 || w_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_vs_ready: seen=%b valid=%b count=%0d, expected seen=1 valid=0 count=0", seen, w_valid, w_count);
        end
        push(c_DATA, 32'd7, 8'h77, 5'b00001);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_abs !== 32'd7 || ev_sop !== 1'b1 || w_count !== 16'd1) begin
            n_fail++;
            $display("FAIL clr_next_ev: ok=%b abs=%h sop=%b count=%0d, expected abs=7 sop=1 count=1",
                     ev_ok, ev_abs, ev_sop, w_count);
        end
    endtask

    task automatic test_wrap_and_saturate();
        pulse_clear();
        push(c_DATA, 32'hFFFF_FFFE, 8'hE1, 5'b00001);
        push(c_DATA, 32'd3,         8'hE2, 5'b00001);
        get_event();
        n_asserts++;
        if (!ev_ok || ev_wabs !== 32'hFFFF_FFFE || ev_abs !== 32'h0000_FFFE) begin
            n_fail++;
            $display("FAIL wrap_ev1: ok=%b wide_abs=%h abs=%h, expected wide_abs=fffffffe abs=0000fffe",
                     ev_ok, ev_wabs, ev_abs);
        end
        get_event();
        n_asserts++;
        if (!ev_ok || ev_wabs !== 32'h0000_0002 || ev_abs !== 32'h0001_0002) begin
            n_fail++;
            $display("FAIL wrap_ev2: ok=%b wide_abs=%h abs=%h, expected wide_abs=00000002 abs=00010002",
                     ev_ok, ev_wabs, ev_abs);
        end
        pulse_clear();
        for (int i = 0; i < 17; i++) push(c_DATA, 32'd0, i[7:0], 5'b00001);
        for (int i = 0; i < 17; i++) begin
            get_event();
            n_asserts++;
            if (!ev_ok || ev_abs !== i) begin
                n_fail++;
                $display("FAIL sat_ev%0d: ok=%b abs=%h, expected abs=%h", i, ev_ok, ev_abs, i);
            end
        end
        n_asserts++;
        if (w_wide_count !== 4'hF || w_count !== 16'd17) begin
            n_fail++;
            $display("FAIL saturate: wide_count=%h count=%0d, expected wide_count=f count=17", w_wide_count, w_count);
        end
        repeat (5) @(negedge fe_clk);
        n_asserts++;
        if (rd_empty_err !== 0 || pop_cnt !== push_cnt) begin
            n_fail++;
            $display("FAIL pop_accounting: rd_when_empty=%0d pops=%0d pushes=%0d, expected 0 and pops==pushes",
                     rd_empty_err, pop_cnt, push_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_time_entries();
        test_backpressure();
        test_packet_framing();
        test_format_error();
        test_clear_priority();
        test_wrap_and_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
